// File: rtl/d_fifo_if.sv
// d_fifo_if -- handshake/data bundle for the d_fifo synchronous FIFO.
//   wr_en, din            : write request and write data (from producer)
//   rd_en                 : read request (from consumer)
//   dout                  : registered read data
//   full, empty, count    : occupancy status
//   overflow, underflow   : one-cycle pulses on rejected write / read
// Modports: master = producer/consumer side, slave = FIFO side.
interface d_fifo_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/d_fifo.sv
// d_fifo -- synchronous FIFO with registered (one-cycle latency) read data.
//   clk  : single clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : d_fifo_if slave modport (wr_en, din, rd_en, dout, full, empty,
//          count, overflow, underflow)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module d_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    d_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             rd_ok;
    logic             wr_ok;

    assign bus.count = count_q;
    assign bus.full  = (count_q == CNT_FULL);
    assign bus.empty = (count_q == '0);

    // A full FIFO still accepts a write when a read frees a slot this cycle;
    // an empty FIFO never satisfies a read from the same-cycle write.
    assign rd_ok = bus.rd_en && !bus.empty;
    assign wr_ok = bus.wr_en && (!bus.full || rd_ok);

    // Storage is not reset; contents are discarded logically via the pointers.
    always_ff @(posedge clk) begin
        if (rst && wr_ok) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            bus.dout      <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.overflow  <= bus.wr_en && !wr_ok;
            bus.underflow <= bus.rd_en && !rd_ok;

            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (rd_ok) begin
                bus.dout <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end

            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_d_fifo.sv
// tb_d_fifo -- directed self-checking bench for d_fifo (WIDTH=2, DEPTH=4).
module tb_d_fifo;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    d_fifo_if #(.WIDTH(2), .DEPTH(4)) bus ();

    d_fifo #(.WIDTH(2), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Apply inputs, take one rising edge, then settle before checks.
    task automatic cyc(input logic r, input logic w, input logic rd, input logic [1:0] d);
        rst       = r;
        bus.wr_en = w;
        bus.rd_en = rd;
        bus.din   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.din = 2'b00;
        #1;

        // Reset with active requests
        cyc(1'b0, 1'b1, 1'b1, 2'b11);
        cyc(1'b0, 1'b1, 1'b1, 2'b11);
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_udf", bus.underflow, 0);

        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        check("idle_empty", bus.empty, 1);

        // Fill and drain
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 2'(i));
            check("fill_count", bus.count, i + 1);
        end
        check("fill_full", bus.full, 1);
        check("fill_empty", bus.empty, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 2'b00);
            check("drain_dout", bus.dout, i);
        end
        check("drain_empty", bus.empty, 1);
        check("drain_full", bus.full, 0);

        // Underflow while empty: dout holds 2'b11
        cyc(1'b1, 1'b0, 1'b1, 2'b00);
        check("udf_pulse", bus.underflow, 1);
        check("udf_dout", bus.dout, 3);
        check("udf_count", bus.count, 0);
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        check("udf_clear", bus.underflow, 0);

        // Refill, then overflow
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 2'(i));
        check("refill_full", bus.full, 1);
        cyc(1'b1, 1'b1, 1'b0, 2'b01);
        check("ovf_pulse", bus.overflow, 1);
        check("ovf_count", bus.count, 4);
        check("ovf_dout", bus.dout, 3);
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        check("ovf_clear", bus.overflow, 0);

        // Simultaneous access while full: contents 0,1,2,3 -> 1,2,3,2
        cyc(1'b1, 1'b1, 1'b1, 2'b10);
        check("simf_dout", bus.dout, 0);
        check("simf_count", bus.count, 4);
        check("simf_ovf", bus.overflow, 0);
        check("simf_full", bus.full, 1);
        cyc(1'b1, 1'b0, 1'b1, 2'b00); check("simf_d1", bus.dout, 1);
        cyc(1'b1, 1'b0, 1'b1, 2'b00); check("simf_d2", bus.dout, 2);
        cyc(1'b1, 1'b0, 1'b1, 2'b00); check("simf_d3", bus.dout, 3);
        cyc(1'b1, 1'b0, 1'b1, 2'b00); check("simf_d4", bus.dout, 2);
        check("simf_empty", bus.empty, 1);

        // Simultaneous access while empty: only the write is taken
        cyc(1'b1, 1'b1, 1'b1, 2'b01);
        check("sime_count", bus.count, 1);
        check("sime_udf", bus.underflow, 1);
        check("sime_dout", bus.dout, 2);
        cyc(1'b1, 1'b0, 1'b1, 2'b00);
        check("sime_read", bus.dout, 1);
        check("sime_empty", bus.empty, 1);
        check("sime_udf_clr", bus.underflow, 0);

        // Wrap: 10 write/read pairs
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 2'(i % 4));
            check("wrap_cnt_w", bus.count, 1);
            cyc(1'b1, 1'b0, 1'b1, 2'b00);
            check("wrap_dout", bus.dout, i % 4);
            check("wrap_cnt_r", bus.count, 0);
        end

        // Reset while full
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 2'b11);
        check("prerst_full", bus.full, 1);
        cyc(1'b0, 1'b1, 1'b0, 2'b01);
        check("midrst_empty", bus.empty, 1);
        check("midrst_count", bus.count, 0);
        check("midrst_dout", bus.dout, 0);
        cyc(1'b1, 1'b1, 1'b0, 2'b10);
        check("post_count", bus.count, 1);
        cyc(1'b1, 1'b0, 1'b1, 2'b00);
        check("post_dout", bus.dout, 2);
        check("post_empty", bus.empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/d_fifo.md
D_FIFO -- requirements
Module: d_fifo

Interface
REQ-001 The module SHALL have parameter WIDTH, default 2, giving the data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of storage entries; legal values are powers of two >= 2.
REQ-003 Port clk SHALL be an input of width 1: the single clock, with all state updating on its rising edge.
REQ-004 Port rst SHALL be an input of width 1: synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-005 Port wr_en SHALL be an input of width 1: write request.
REQ-006 Port din SHALL be an input of width WIDTH: write data.
REQ-007 Port rd_en SHALL be an input of width 1: read request.
REQ-008 Port dout SHALL be an output reg of width WIDTH: registered read data, consumed by the downstream D register stage.
REQ-009 Port full SHALL be an output of width 1: high when count == DEPTH.
REQ-010 Port empty SHALL be an output of width 1: high when count == 0.
REQ-011 Port count SHALL be an output of width clog2(DEPTH)+1: the number of stored entries.
REQ-012 Port overflow SHALL be an output reg of width 1: one-cycle pulse on a rejected write.
REQ-013 Port underflow SHALL be an output reg of width 1: one-cycle pulse on a rejected read.

Function
REQ-014 Storage SHALL be a DEPTH x WIDTH array with clog2(DEPTH)-bit write and read pointers that wrap from DEPTH-1 to 0 without reaching any illegal state.
REQ-015 A write SHALL be accepted at a rising edge iff wr_en=1 and (full=0 or an accepted read occurs in the same cycle): din is stored at wr_ptr and wr_ptr increments.
REQ-016 A read SHALL be accepted at a rising edge iff rd_en=1 and empty=0: dout <= mem[rd_ptr] and rd_ptr increments.
REQ-017 dout SHALL hold its previous value in every cycle without an accepted read.
REQ-018 Read latency SHALL be one cycle: data appears on dout immediately after the edge that accepts the read; there is no first-word fall-through.
REQ-019 count SHALL change by +1 on an accepted write only, by -1 on an accepted read only, and stay unchanged when both or neither are accepted.
REQ-020 full and empty SHALL be derived combinationally from count and SHALL never be high simultaneously.
REQ-021 When empty, simultaneous wr_en and rd_en SHALL accept only the write; the read is rejected, underflow pulses, and the written data is first readable on the next cycle.
REQ-022 When full, simultaneous wr_en and rd_en SHALL accept both; count stays DEPTH and overflow stays 0.
REQ-023 overflow SHALL be 1 for exactly the cycle after an edge where wr_en=1 and the write was rejected, and 0 otherwise.
REQ-024 underflow SHALL be 1 for exactly the cycle after an edge where rd_en=1 and the read was rejected, and 0 otherwise.
REQ-025 A rejected write or read SHALL not modify the memory, pointers, count or dout.
REQ-026 Data SHALL leave the FIFO in exactly the order it was accepted, including across pointer wrap.

Reset
REQ-027 When rst=0 at a rising edge, the block SHALL clear wr_ptr, rd_ptr and count to 0, set dout, overflow and underflow to 0, and therefore drive empty=1 and full=0.
REQ-028 Reset SHALL take priority over wr_en and rd_en in the same cycle, and stored contents are logically discarded; memory array contents need not be cleared.
REQ-029 Reset asserted mid-operation, including while full, SHALL yield the REQ-027 state after that edge, and the first write accepted after rst returns to 1 SHALL be the first word read.

Verification
REQ-030 The bench SHALL cover reset: hold rst=0 for 2 edges with wr_en=rd_en=1 and din=2'b11 -> count=0, empty=1, full=0, dout=2'b00, no pulses.
REQ-031 The bench SHALL cover fill and drain: write 2'b00, 2'b01, 2'b10, 2'b11 -> full=1 and count=4; then read 4 times -> dout sequence 00, 01, 10, 11, then empty=1.
REQ-032 The bench SHALL cover overflow and underflow: write while full with din=2'b01 -> overflow=1 for one cycle and count stays 4; read while empty -> underflow=1 for one cycle and dout is unchanged.
REQ-033 The bench SHALL cover simultaneous access: when full, wr_en=rd_en=1 with din=2'b10 -> dout = oldest word, count=4; when empty, wr_en=rd_en=1 with din=2'b01 -> count=1, underflow=1, and the next read gives dout=2'b01.
REQ-034 The bench SHALL cover wrap: perform 10 interleaved write/read pairs with din = i mod 4 -> each dout equals the matching din in order, and count never exceeds 1.
REQ-035 The bench SHALL cover reset while full: rst=0 for one edge -> empty=1; then write 2'b10 and read -> dout=2'b10.
